// File: rtl/wbarb_pkg.sv
// wbarb_pkg: shared types and constants for the register-file write-port arbiter.
//   lu_entry_t  : one buffered long-latency-unit result (valid, dest, data)
//   XZR         : zero register index; never written
//   DEF_DEPTH   : default LU result buffer depth
// Optional feature macro used by the arbiter: WBARB_STATS_EN.
package wbarb_pkg;

  localparam int unsigned DEF_DEPTH    = 2;
  localparam int unsigned ENTRY_DATA_W = 64;
  localparam int unsigned ENTRY_REG_W  = 5;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_REG_W-1:0]  dest;
    logic [ENTRY_DATA_W-1:0] data;
  } lu_entry_t;

endpackage

// File: rtl/wbarb_fifo.sv
// wbarb_fifo: in-order circular buffer of pending LU results.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_push/i_push_entry append an entry at the tail
//   i_pop               retire the head entry (valid or squashed)
//   i_squash_en/_dest   invalidate every valid entry whose dest matches
//   o_head              current head entry
//   o_count             number of occupied slots (squashed ones included)
//   o_mask              registered OR of dest decodes of valid entries
//   o_squash_num        entries invalidated this cycle (WBARB_STATS_EN only)
module wbarb_fifo
  import wbarb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned REG_W = ENTRY_REG_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_push,
  input  lu_entry_t                 i_push_entry,
  input  logic                      i_pop,
  input  logic                      i_squash_en,
  input  logic [REG_W-1:0]          i_squash_dest,
  output lu_entry_t                 o_head,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [31:0]               o_mask
`ifdef WBARB_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]    o_squash_num
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lu_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_mask;

  lu_entry_t        w_mem_nxt [DEPTH];
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_tail_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      w_mask_nxt;
  logic [CNT_W-1:0] w_squash_num;

  // Squash first, then pop, then push: the pushed beat is younger than the
  // squashing WB write and must survive it.
  always_comb begin
    w_mem_nxt    = r_mem;
    w_head_nxt   = r_head;
    w_tail_nxt   = r_tail;
    w_squash_num = '0;
    w_mask_nxt   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_squash_en && r_mem[PTR_W'(i)].valid &&
          (r_mem[PTR_W'(i)].dest == i_squash_dest)) begin
        w_mem_nxt[PTR_W'(i)].valid = 1'b0;
        w_squash_num               = w_squash_num + CNT_W'(1);
      end
    end
    if (i_pop) begin
      w_mem_nxt[r_head].valid = 1'b0;
      w_head_nxt              = r_head + PTR_W'(1);
    end
    if (i_push) begin
      w_mem_nxt[r_tail] = i_push_entry;
      w_tail_nxt        = r_tail + PTR_W'(1);
    end
    w_count_nxt = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_mem_nxt[PTR_W'(i)].valid)
        w_mask_nxt[w_mem_nxt[PTR_W'(i)].dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_mask  <= '0;
    end else begin
      r_mem   <= w_mem_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_mask  = r_mask;
`ifdef WBARB_STATS_EN
  assign o_squash_num = w_squash_num;
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the WB stage
// (always wins) and a long-latency unit whose results queue in wbarb_fifo.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   wb_valid/regWrite/destReg/data   WB stage write request
//   lu_valid/ready/destReg/data      LU result handshake
//   RegWrite/WriteRegister/WriteData registered write port (1-cycle latency)
//   busy_mask                   registers targeted by live buffered LU writes
//   stall_cycles, squash_count  saturating counters (WBARB_STATS_EN only)
module wb_port_arbiter
  import wbarb_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = ENTRY_DATA_W,
  parameter int unsigned REG_W  = ENTRY_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_regWrite,
  input  logic [REG_W-1:0]  wb_destReg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_W-1:0]  lu_destReg,
  input  logic [DATA_W-1:0] lu_data,
  output logic              RegWrite,
  output logic [REG_W-1:0]  WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       busy_mask
`ifdef WBARB_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       squash_count
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              r_lu_ready;
  logic              r_RegWrite;
  logic [REG_W-1:0]  r_WriteRegister;
  logic [DATA_W-1:0] r_WriteData;

  lu_entry_t         w_head;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_empty;
  logic              w_wb_req;
  logic              w_lu_acc;
  logic              w_lu_zr;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_grant;
  logic [REG_W-1:0]  w_gdest;
  logic [DATA_W-1:0] w_gdata;

  assign w_empty  = (w_count == '0);
  assign w_wb_req = wb_valid & wb_regWrite & (wb_destReg != XZR);
  assign w_lu_acc = lu_valid & r_lu_ready;
  assign w_lu_zr  = (lu_destReg == XZR);

  always_comb begin
    w_grant  = 1'b0;
    w_bypass = 1'b0;
    w_gdest  = '0;
    w_gdata  = '0;
    if (w_wb_req) begin
      w_grant = 1'b1;
      w_gdest = wb_destReg;
      w_gdata = wb_data;
    end else if (!w_empty && w_head.valid) begin
      w_grant = 1'b1;
      w_gdest = w_head.dest;
      w_gdata = w_head.data;
    end else if (w_empty && w_lu_acc && !w_lu_zr) begin
      w_grant  = 1'b1;
      w_bypass = 1'b1;
      w_gdest  = lu_destReg;
      w_gdata  = lu_data;
    end
    // A squashed head retires without using the port, even under a WB write.
    w_pop       = !w_empty && (!w_head.valid || !w_wb_req);
    w_push      = w_lu_acc && !w_lu_zr && !w_bypass;
    w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

`ifdef WBARB_STATS_EN
  logic [CNT_W-1:0] w_squash_num;
`endif

  wbarb_fifo #(
    .DEPTH (DEPTH),
    .REG_W (REG_W)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_push),
    .i_push_entry  ('{valid: 1'b1, dest: lu_destReg, data: lu_data}),
    .i_pop         (w_pop),
    .i_squash_en   (w_wb_req),
    .i_squash_dest (wb_destReg),
    .o_head        (w_head),
    .o_count       (w_count),
    .o_mask        (busy_mask)
`ifdef WBARB_STATS_EN
    ,
    .o_squash_num  (w_squash_num)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lu_ready      <= 1'b0;
      r_RegWrite      <= 1'b0;
      r_WriteRegister <= '0;
      r_WriteData     <= '0;
    end else begin
      // Based on next occupancy, so a same-cycle pop cannot open a slot early.
      r_lu_ready <= (w_count_nxt < CNT_W'(DEPTH));
      r_RegWrite <= w_grant;
      if (w_grant) begin
        r_WriteRegister <= w_gdest;
        r_WriteData     <= w_gdata;
      end
    end
  end

  assign lu_ready      = r_lu_ready;
  assign RegWrite      = r_RegWrite;
  assign WriteRegister = r_WriteRegister;
  assign WriteData     = r_WriteData;

`ifdef WBARB_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_squash_count;
  logic [32:0] w_squash_sum;

  assign w_squash_sum = {1'b0, r_squash_count} + 33'(w_squash_num);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_squash_count <= '0;
    end else begin
      if (lu_valid && !r_lu_ready && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      r_squash_count <= w_squash_sum[32] ? '1 : w_squash_sum[31:0];
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign squash_count = r_squash_count;
`endif

endmodule
